// File: rtl/vga_axi_lite_slave_regs.sv
// vga_axi_lite_slave_regs: AXI4-Lite slave holding the four VGA control registers
module vga_axi_lite_slave_regs #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [31:0] REG0_RST           = 32'h0,
    parameter logic [31:0] REG1_RST           = 32'h0,
    parameter logic [31:0] REG2_RST           = 32'h0,
    parameter logic [31:0] REG3_RST           = 32'h0
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
    output logic [3:0]                      reg_wr_o
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t        w_state;
    r_state_t        r_state;
    logic [1:0]      addr_q;
    logic [DW-1:0]   wdata_q;
    logic [SW-1:0]   wstrb_q;
    logic [DW-1:0]   regs [4];
    logic            aw_hs, w_hs, ar_hs, do_wr;
    logic [1:0]      wr_sel;
    logic [DW-1:0]   wr_data;
    logic [SW-1:0]   wr_strb;
    logic            unused_ok;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    // A write lands on the edge where the last of the two handshakes completes
    assign do_wr = (w_state == W_IDLE && aw_hs && w_hs) ||
                   (w_state == W_HAVE_A && w_hs) ||
                   (w_state == W_HAVE_D && aw_hs);
    assign wr_sel  = (w_state == W_HAVE_A) ? addr_q : S_AXI_AWADDR[3:2];
    assign wr_data = (w_state == W_HAVE_D) ? wdata_q : S_AXI_WDATA;
    assign wr_strb = (w_state == W_HAVE_D) ? wstrb_q : S_AXI_WSTRB;

    assign S_AXI_BRESP = 2'b00;
    assign S_AXI_RRESP = 2'b00;
    assign reg0_o = regs[0];
    assign reg1_o = regs[1];
    assign reg2_o = regs[2];
    assign reg3_o = regs[3];
    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Write channel FSM: AW and W may arrive in either order; readies are registered from the next state
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state       <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs && w_hs) begin
                        w_state       <= W_RESP;
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b0;
                        S_AXI_BVALID  <= 1'b1;
                    end else if (aw_hs) begin
                        w_state       <= W_HAVE_A;
                        addr_q        <= S_AXI_AWADDR[3:2];
                        S_AXI_AWREADY <= 1'b0;
                    end else if (w_hs) begin
                        w_state      <= W_HAVE_D;
                        wdata_q      <= S_AXI_WDATA;
                        wstrb_q      <= S_AXI_WSTRB;
                        S_AXI_WREADY <= 1'b0;
                    end else begin
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                    end
                end
                W_HAVE_A: begin
                    if (w_hs) begin
                        w_state      <= W_RESP;
                        S_AXI_WREADY <= 1'b0;
                        S_AXI_BVALID <= 1'b1;
                    end
                end
                W_HAVE_D: begin
                    if (aw_hs) begin
                        w_state       <= W_RESP;
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_BVALID  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        w_state       <= W_IDLE;
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Register file: byte-lane masked update plus a one-cycle write strobe per register
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            regs[0]  <= REG0_RST;
            regs[1]  <= REG1_RST;
            regs[2]  <= REG2_RST;
            regs[3]  <= REG3_RST;
            reg_wr_o <= '0;
        end else begin
            reg_wr_o <= do_wr ? 4'b0001 << wr_sel : 4'b0000;
            if (do_wr)
                for (int n = 0; n < SW; n++)
                    if (wr_strb[n])
                        regs[wr_sel][8*n +: 8] <= wr_data[8*n +: 8];
        end
    end

    // Read channel FSM: RDATA is captured at the AR handshake and held until RREADY
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state       <= R_DATA;
                        S_AXI_RDATA   <= regs[S_AXI_ARADDR[3:2]];
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_ARREADY <= 1'b0;
                    end else begin
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        r_state       <= R_IDLE;
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule
